// File: rtl/uart_rx_check.sv
// 8N1 UART receiver with framing check, saturating byte count, running checksum and idle-line timeout.
// Optional feature macro: UART_RX_CHECKSUM_EN (modulo-256 checksum of good bytes; tied to zero when undefined).
module uart_rx_check #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IDLE_BITS    = 32,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RxD,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [CNT_W-1:0] byte_count,
  output logic [7:0]       checksum,
  output logic             stream_done,
  output logic             busy
);

  localparam int TMR_W    = $clog2(CLKS_PER_BIT);
  localparam int IDLE_LIM = IDLE_BITS * CLKS_PER_BIT;
  localparam int IDL_W    = $clog2(IDLE_LIM);
  localparam logic [TMR_W-1:0] HALF_M1 = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_M1 = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDL_W-1:0] IDLE_M1 = IDL_W'(IDLE_LIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_sync1, r_sync2;
  logic               w_rx_s;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [IDL_W-1:0]   r_idle_cnt;
  logic               r_armed;
  logic               w_shift_en, w_good, w_bad, w_idle_hi;

  assign w_rx_s    = r_sync2;
  assign w_idle_hi = (r_state == S_IDLE) && w_rx_s;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (!w_rx_s) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_timer == HALF_M1) begin
          w_timer_nxt = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_timer == FULL_M1) begin
          w_timer_nxt = '0;
          w_shift_en  = 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_timer == FULL_M1) begin
          w_timer_nxt = '0;
          if (w_rx_s) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_timer_nxt = '0;
        if (w_rx_s) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      byte_count  <= '0;
      r_idle_cnt  <= '0;
      r_armed     <= 1'b0;
      stream_done <= 1'b0;
    end else begin
      r_sync1     <= RxD;
      r_sync2     <= r_sync1;
      r_timer     <= w_timer_nxt;
      data_valid  <= w_good;
      frame_err   <= w_bad;
      stream_done <= 1'b0;
      if (r_state != S_DATA) r_bit_idx <= '0;
      else if (w_shift_en)   r_bit_idx <= r_bit_idx + 1'b1;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_good) begin
        data_out <= r_shift;
        if (byte_count != {CNT_W{1'b1}}) byte_count <= byte_count + 1'b1;
      end
      // Idle counter saturates so a long idle line cannot wrap into a second pulse.
      if (!w_idle_hi)                 r_idle_cnt <= '0;
      else if (r_idle_cnt != IDLE_M1) r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_good) begin
        r_armed <= 1'b1;
      end else if (r_armed && w_idle_hi && (r_idle_cnt == IDLE_M1)) begin
        stream_done <= 1'b1;
        r_armed     <= 1'b0;
      end
    end
  end

`ifdef UART_RX_CHECKSUM_EN
  logic [7:0] r_checksum;
  always_ff @(posedge clk) begin
    if (rst)         r_checksum <= '0;
    else if (w_good) r_checksum <= r_checksum + r_shift;
  end
  assign checksum = r_checksum;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: doc/uart_rx_check.md
# uart_rx_check

Serial receiver and stream checker that sits directly downstream of the chip's `TxD` pin. It consumes the 8N1 byte stream produced by the transmit stage, validates framing, presents each received byte with a one-cycle strobe, and keeps a running byte count and checksum. An idle-line timeout flags the end of a compressed-image transfer. It is used in loopback synthesis builds and as the bench-side monitor for the full compression pipeline.

## Interface
- `CLKS_PER_BIT`, 868, `clk` cycles per UART bit; must be even and ≥ 8.
- `IDLE_BITS`, 32, line-high bit times after the last byte before `stream_done`.
- `CNT_W`, 16, width of `byte_count`.
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `RxD` in 1 — asynchronous serial input, idle high.
- `data_out` out 8 — last good byte; held until the next good byte.
- `data_valid` out 1 — one-cycle pulse; `data_out` is new this cycle.
- `frame_err` out 1 — one-cycle pulse; stop bit sampled low.
- `byte_count` out CNT_W — good bytes since reset; saturates at all-ones.
- `checksum` out 8 — running checksum of good bytes (see Configuration).
- `stream_done` out 1 — one-cycle pulse at idle timeout.
- `busy` out 1 — high in every state except IDLE.

## Operation
- `RxD` passes through a 2-FF synchronizer, reset value 1; the FSM uses only the synchronized bit `rx_s`.
- States:
  - IDLE: on `rx_s`==0, clear the bit timer and go to START.
  - START: at timer == CLKS_PER_BIT/2−1, sample the line.
    - If `rx_s`==1, the start bit was a glitch: return to IDLE with no outputs.
    - Otherwise restart the timer and go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first, into a shift register. After the 8th sample, go to STOP.
  - STOP: at CLKS_PER_BIT, sample the stop bit.
    - If 1: update `data_out`, pulse `data_valid`, add 1 to `byte_count` (saturating), update `checksum`, arm the idle detector, go to IDLE.
    - If 0: pulse `frame_err`, leave the data registers unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition being taken as a new start bit.
- Idle detector:
  - Counts consecutive IDLE cycles with `rx_s`==1; clears on any other state or a low line.
  - When armed and the count reaches IDLE_BITS·CLKS_PER_BIT−1: pulse `stream_done` and disarm.
  - It re-arms only on the next good byte, so there is one pulse per burst.
- A frame error does not arm the idle detector.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, `byte_count`=0, `checksum`=0, `stream_done`=0, `busy`=0, state=IDLE, synchronizer=1.
- Synchronizer latency: 2 cycles from the `RxD` edge to `rx_s`.
- The start-bit falling edge at `RxD` on cycle t lands the stop-bit sample at t + 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (±1).
- `data_valid`, `frame_err` and the count/checksum updates are registered: they appear on the cycle after the stop sample.
- `data_valid` and `frame_err` are never high together.
- `stream_done` never coincides with `data_valid`.
- Back-to-back frames: a new start edge is accepted on the first IDLE cycle after STOP. This tolerates up to ~½ bit of stop-bit shortening.
- `rst` asserted mid-frame returns to IDLE on the next edge and clears all counters. A partial byte is discarded without any pulse.
- `byte_count` at all-ones stays there; `checksum` keeps updating.

## Configuration
- `UART_RX_CHECKSUM_EN` defined:
  - `checksum` = 8-bit modulo-256 sum of all good bytes since reset.
  - The sum wraps with no saturation.
- `UART_RX_CHECKSUM_EN` undefined:
  - The checksum adder and register are not compiled in.
  - `checksum` is tied to 8'h00.
  - All other behaviour is identical.

## Test plan
All scenarios use CLKS_PER_BIT=16 and IDLE_BITS=4.
- Single byte 8'hA5, correct stop bit → one `data_valid` pulse, `data_out`=8'hA5, `byte_count`=1, `checksum`=8'hA5 (8'h00 without the macro), `frame_err` never high.
- Bytes 8'hFF, 8'h02, 8'h10 back to back, no idle between frames → three `data_valid` pulses, `byte_count`=3, `checksum`=8'h11, then exactly one `stream_done` 64±3 cycles after the last stop sample.
- 4-cycle low glitch on idle `RxD` → returns to IDLE from START, no pulses, `byte_count`=0, `busy` back to 0 within 12 cycles.
- Frame 8'h3C with stop bit driven 0, line held low a further 40 cycles, then 8'h81 sent correctly → one `frame_err`, `data_out` stays 0 until the 8'h81 `data_valid`, `byte_count`=1.
- `rst` pulsed during DATA bit 4 of 8'h55, followed by a clean 8'h0F → no pulse for 8'h55, then `data_out`=8'h0F, `byte_count`=1.
- 300 frames with `CNT_W`=8 → `byte_count` saturates at 8'hFF; `checksum` equals the modulo-256 sum of all 300 bytes.
